// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, pixel types and colour helpers
// shared by the VGA sink. Build option (top): VGA_TEST_PATTERN_EN.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned H_FP_DEF     = 16;
   localparam int unsigned H_SYNC_DEF   = 96;
   localparam int unsigned H_BP_DEF     = 48;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned V_FP_DEF     = 10;
   localparam int unsigned V_SYNC_DEF   = 2;
   localparam int unsigned V_BP_DEF     = 33;

   localparam int unsigned H_TOTAL_DEF =
      H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int unsigned V_TOTAL_DEF =
      V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
   localparam int unsigned HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
   localparam int unsigned VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;

   localparam logic [10:0] BAR_W = 11'd80;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   typedef struct packed {
      logic hs;
      logic vs;
      logic act;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

   // MSB replication keeps both ends exact: 111->F, 000->0, 11->F
   function automatic rgb444_t rgb332_to_444(input rgb332_t p);
      rgb444_t o;
      o.r = {p.r, p.r[2]};
      o.g = {p.g, p.g[2]};
      o.b = {p.b, p.b};
      return o;
   endfunction

   // 8 bars of 80 px: W Y C G M R B K
   function automatic rgb332_t bar_colour(input logic [10:0] x);
      logic [10:0] idx;
      idx = x / BAR_W;
      case (idx)
         11'd0:   return rgb332_t'(8'hFF);
         11'd1:   return rgb332_t'(8'hFC);
         11'd2:   return rgb332_t'(8'h1F);
         11'd3:   return rgb332_t'(8'h1C);
         11'd4:   return rgb332_t'(8'hE3);
         11'd5:   return rgb332_t'(8'hE0);
         11'd6:   return rgb332_t'(8'h03);
         default: return rgb332_t'(8'h00);
      endcase
   endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: WIDTH x DEPTH shift register with a reset value.
// Ports: clk, resetN (async, low), d_i in, q_o = d_i delayed DEPTH clocks.
module vga_sync_delay #(
   parameter int unsigned      WIDTH   = 3,
   parameter int unsigned      DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             resetN,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] sr_q [DEPTH];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < DEPTH; i++) sr_q[i] <= RST_VAL;
      end else begin
         sr_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out: 640x480 scan generator and VGA DAC driver (pipeline sink).
// In: clk, resetN (async, low), RGBIn (RGB332), testPattern.
// Out: pixelX/pixelY counters, startOfFrame, oVGA_R/G/B, oHS, oVS, oBlankN.
// Build option VGA_TEST_PATTERN_EN: colour bars replace RGBIn when testPattern=1.
module vga_timing_out
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned H_FP     = H_FP_DEF,
   parameter int unsigned H_SYNC   = H_SYNC_DEF,
   parameter int unsigned H_BP     = H_BP_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned V_FP     = V_FP_DEF,
   parameter int unsigned V_SYNC   = V_SYNC_DEF,
   parameter int unsigned V_BP     = V_BP_DEF,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [7:0]  RGBIn,
   input  logic        testPattern,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic [3:0]  oVGA_R,
   output logic [3:0]  oVGA_G,
   output logic [3:0]  oVGA_B,
   output logic        oHS,
   output logic        oVS,
   output logic        oBlankN
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] hCnt_q, hCnt_d;
   logic [10:0] vCnt_q, vCnt_d;
   sync_t       raw, dly;
   rgb332_t     pix;
   rgb444_t     col;
   logic [3:0]  r_q, g_q, b_q;
   logic        hs_q, vs_q, blankN_q;

   always_comb begin
      hCnt_d = hCnt_q + 11'd1;
      vCnt_d = vCnt_q;
      if (hCnt_q == H_LAST) begin
         hCnt_d = '0;
         vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 11'd1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
      end
   end

   always_comb begin
      raw     = SYNC_IDLE;
      raw.hs  = !(hCnt_q >= HS_FIRST && hCnt_q <= HS_LAST);
      raw.vs  = !(vCnt_q >= VS_FIRST && vCnt_q <= VS_LAST);
      raw.act = (hCnt_q < H_ACT) && (vCnt_q < V_ACT);
   end

   vga_sync_delay #(
      .WIDTH   (3),
      .DEPTH   (PIPE_LAT),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_dly (
      .clk    (clk),
      .resetN (resetN),
      .d_i    (raw),
      .q_o    (dly)
   );

`ifdef VGA_TEST_PATTERN_EN
   logic [10:0] x_dly;

   // x travels with the sync bits so bars line up with blanking
   vga_sync_delay #(
      .WIDTH   (11),
      .DEPTH   (PIPE_LAT),
      .RST_VAL ('0)
   ) u_x_dly (
      .clk    (clk),
      .resetN (resetN),
      .d_i    (hCnt_q),
      .q_o    (x_dly)
   );

   always_comb begin
      pix = rgb332_t'(RGBIn);
      if (testPattern) pix = bar_colour(x_dly);
   end
`else
   logic unused_tp;
   assign unused_tp = testPattern;
   assign pix       = rgb332_t'(RGBIn);
`endif

   assign col = rgb332_to_444(pix);

   // colour is gated by the delayed active flag so blanking is black
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
         hs_q     <= 1'b1;
         vs_q     <= 1'b1;
         blankN_q <= 1'b0;
      end else begin
         hs_q     <= dly.hs;
         vs_q     <= dly.vs;
         blankN_q <= dly.act;
         if (dly.act) begin
            r_q <= col.r;
            g_q <= col.g;
            b_q <= col.b;
         end else begin
            r_q <= '0;
            g_q <= '0;
            b_q <= '0;
         end
      end
   end

   assign pixelX       = hCnt_q;
   assign pixelY       = vCnt_q;
   assign startOfFrame = resetN && (hCnt_q == '0) && (vCnt_q == '0);
   assign oVGA_R       = r_q;
   assign oVGA_G       = g_q;
   assign oVGA_B       = b_q;
   assign oHS          = hs_q;
   assign oVS          = vs_q;
   assign oBlankN      = blankN_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: bench for the VGA sink, random pixels vs a
// coordinate-arithmetic model, plus table and reset sequences.
`timescale 1ns/1ps
module tb_vga_timing_out;

   // vertical timing shortened so one frame is 15200 clocks
   localparam int HT    = 800;
   localparam int VA    = 12;
   localparam int VFP   = 2;
   localparam int VSY   = 2;
   localparam int VBP   = 3;
   localparam int VT    = VA + VFP + VSY + VBP;
   localparam int VSS   = VA + VFP;
   localparam int FRAME = HT * VT;
   localparam int LAT   = 2;

   typedef logic [37:0] obs_t;
   localparam obs_t RST_OBS =
      {11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000};

   typedef struct {
      logic [7:0] rgb;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } vec_t;

   logic        clk = 1'b0;
   logic        resetN;
   logic [7:0]  RGBIn;
   logic        testPattern;
   logic [10:0] pixelX, pixelY;
   logic        startOfFrame;
   logic [3:0]  oVGA_R, oVGA_G, oVGA_B;
   logic        oHS, oVS, oBlankN;

   int   checks = 0;
   int   errors = 0;
   int   k = 0;
   logic tp_rand = 1'b1;

   vga_timing_out #(
      .V_ACTIVE (VA),
      .V_FP     (VFP),
      .V_SYNC   (VSY),
      .V_BP     (VBP),
      .PIPE_LAT (LAT)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .RGBIn        (RGBIn),
      .testPattern  (testPattern),
      .pixelX       (pixelX),
      .pixelY       (pixelY),
      .startOfFrame (startOfFrame),
      .oVGA_R       (oVGA_R),
      .oVGA_G       (oVGA_G),
      .oVGA_B       (oVGA_B),
      .oHS          (oHS),
      .oVS          (oVS),
      .oBlankN      (oBlankN)
   );

   always #5 clk = ~clk;

   function automatic obs_t obs();
      return {pixelX, pixelY, startOfFrame, oHS, oVS, oBlankN,
              oVGA_R, oVGA_G, oVGA_B};
   endfunction

   function automatic logic [11:0] expand(input logic [7:0] p);
      int r, g, b;
      r = int'(p[7:5]);
      g = int'(p[4:2]);
      b = int'(p[1:0]);
      return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5)};
   endfunction

   function automatic logic [7:0] bar(input int x);
      case (x / 80)
         0:       return 8'hFF;
         1:       return 8'hFC;
         2:       return 8'h1F;
         3:       return 8'h1C;
         4:       return 8'hE3;
         5:       return 8'hE0;
         6:       return 8'h03;
         default: return 8'h00;
      endcase
   endfunction

   task automatic check_obs(input string name, input obs_t got,
                            input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s k=%0d got %h expected %h", name, k, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got,
                            input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // k = clock edges since reset release; outputs show coords k-LAT-1
   task automatic check_model();
      int c, x, y;
      logic ehs, evs, eact;
      logic [7:0] px;
      logic [11:0] ec;
      obs_t exp;
      ehs = 1'b1; evs = 1'b1; eact = 1'b0; x = 0;
      if (k >= LAT + 1) begin
         c    = k - LAT - 1;
         x    = c % HT;
         y    = (c / HT) % VT;
         ehs  = !(x >= 656 && x <= 751);
         evs  = !(y >= VSS && y <= VSS + 1);
         eact = (x < 640) && (y < VA);
      end
      px = RGBIn;
`ifdef VGA_TEST_PATTERN_EN
      if (testPattern) px = bar(x);
`endif
      ec  = eact ? expand(px) : 12'h000;
      exp = {11'(k % HT), 11'((k / HT) % VT), (k % FRAME) == 0,
             ehs, evs, eact, ec};
      check_obs("model", obs(), exp);
   endtask

   task automatic step(input logic [7:0] rgb);
      RGBIn = rgb;
      if (tp_rand) testPattern = 1'($urandom_range(0, 1));
      @(posedge clk);
      k++;
      @(negedge clk);
      check_model();
   endtask

   task automatic run_to(input int x, input int y);
      int n;
      n = 0;
      while (!(int'(pixelX) == x && int'(pixelY) == y) && n < 2 * FRAME) begin
         step(8'($urandom));
         n++;
      end
      check_int("run_to_bound", int'(n >= 2 * FRAME), 0);
   endtask

   initial begin
      vec_t tbl [8];
      int maxx, maxy, hs_low, vs_low, act_n, sof_n, sof_k;
      int x656, hs_fall, white_n, blank_n, black_n;
      logic prev_hs;

      tbl = '{
         '{8'hFF,         4'hF, 4'hF, 4'hF},
         '{8'h00,         4'h0, 4'h0, 4'h0},
         '{8'b100_010_01, 4'h9, 4'h4, 4'h5},
         '{8'hE0,         4'hF, 4'h0, 4'h0},
         '{8'h1C,         4'h0, 4'hF, 4'h0},
         '{8'h03,         4'h0, 4'h0, 4'hF},
         '{8'b001_110_10, 4'h2, 4'hD, 4'hA},
         '{8'b011_101_00, 4'h6, 4'hB, 4'h0}
      };

      resetN = 1'b1;
      RGBIn = 8'hA5;
      testPattern = 1'b0;
      #2 resetN = 1'b0;
      repeat (3) @(negedge clk);
      check_obs("reset", obs(), RST_OBS);
      resetN = 1'b1;
      k = 0;
      #1 check_model();

      // one full frame of random pixels
      maxx = 0; maxy = 0; hs_low = 0; vs_low = 0; act_n = 0;
      sof_n = 0; sof_k = -1; x656 = -1; hs_fall = -1; prev_hs = 1'b1;
      for (int i = 0; i < FRAME; i++) begin
         step(8'($urandom));
         if (int'(pixelX) > maxx) maxx = int'(pixelX);
         if (int'(pixelY) > maxy) maxy = int'(pixelY);
         if (!oHS) hs_low++;
         if (!oVS) vs_low++;
         if (oBlankN) act_n++;
         if (startOfFrame) begin sof_n++; sof_k = k; end
         if (pixelX == 11'd656 && x656 < 0) x656 = k;
         if (!oHS && prev_hs && hs_fall < 0) hs_fall = k;
         prev_hs = oHS;
      end
      check_int("sof_count", sof_n, 1);
      check_int("sof_period", sof_k, FRAME);
      check_int("max_x", maxx, HT - 1);
      check_int("max_y", maxy, VT - 1);
      check_int("hs_low", hs_low, 96 * VT);
      check_int("hs_lag", hs_fall - x656, LAT + 1);
      check_int("vs_low", vs_low, 2 * HT);
      check_int("active", act_n, 640 * VA);

      // colour expansion table, held mid-line
      tp_rand = 1'b0;
      testPattern = 1'b0;
      run_to(100, 1);
      for (int i = 0; i < 8; i++) begin
         repeat (4) step(tbl[i].rgb);
         check_int("table", int'({oBlankN, oVGA_R, oVGA_G, oVGA_B}),
                   int'({1'b1, tbl[i].r, tbl[i].g, tbl[i].b}));
      end

      // white held for a line: 640 lit, rest black
      run_to(0, 3);
      white_n = 0; blank_n = 0;
      for (int i = 0; i < HT; i++) begin
         step(8'hFF);
         if ({oVGA_R, oVGA_G, oVGA_B} == 12'hFFF) white_n++;
         if (oBlankN) blank_n++;
      end
      check_int("white_line", white_n, 640);
      check_int("blank_line", blank_n, 640);

`ifdef VGA_TEST_PATTERN_EN
      run_to(0, 5);
      testPattern = 1'b1;
      white_n = 0; black_n = 0;
      for (int i = 0; i < HT; i++) begin
         step(8'($urandom));
         if (oBlankN && {oVGA_R, oVGA_G, oVGA_B} == 12'hFFF) white_n++;
         if (oBlankN && {oVGA_R, oVGA_G, oVGA_B} == 12'h000) black_n++;
      end
      check_int("bar_white", white_n, 80);
      check_int("bar_black", black_n, 80);
      testPattern = 1'b0;
`endif

      // asynchronous reset in the middle of the picture
      tp_rand = 1'b1;
      run_to(300, 10);
      #1 resetN = 1'b0;
      #1 check_obs("async_reset", obs(), RST_OBS);
      @(posedge clk);
      @(negedge clk);
      check_obs("held_reset", obs(), RST_OBS);
      resetN = 1'b1;
      k = 0;
      #1 check_model();
      repeat (900) step(8'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
